// File: rtl/otter_cu_fsm_if.sv
// Control-unit bus: decoder/memory status into the CU, datapath control out of it.
//   master : the control unit (drives enables, INT_TAKEN, BUS_ERR, INSTRET)
//   slave  : the datapath side (drives opcode, funct3, memory ready, interrupt inputs)
interface otter_cu_fsm_if;
    logic [6:0]  CU_OPCODE;
    logic [2:0]  CU_FUNCT3;
    logic        CU_MEM_RDY;
    logic        CU_INTR;
    logic        CU_MIE;
    logic        PC_WRITE;
    logic        PC_RST;
    logic        MEM_RDEN1;
    logic        MEM_RDEN2;
    logic        MEM_WE2;
    logic        REG_WRITE;
    logic        CSR_WE;
    logic        INT_TAKEN;
    logic        BUS_ERR;
    logic [31:0] INSTRET;

    modport master (
        input  CU_OPCODE, CU_FUNCT3, CU_MEM_RDY, CU_INTR, CU_MIE,
        output PC_WRITE, PC_RST, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
               REG_WRITE, CSR_WE, INT_TAKEN, BUS_ERR, INSTRET
    );

    modport slave (
        output CU_OPCODE, CU_FUNCT3, CU_MEM_RDY, CU_INTR, CU_MIE,
        input  PC_WRITE, PC_RST, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
               REG_WRITE, CSR_WE, INT_TAKEN, BUS_ERR, INSTRET
    );
endinterface

// File: rtl/otter_cu_fsm.sv
// OTTER control-unit FSM: sequences fetch/execute/writeback one instruction at a time,
// takes interrupts at instruction boundaries and traps on memory-ready timeouts.
//   CU_CLK   : clock, rising edge
//   CU_RST_N : asynchronous active-low reset
//   bus      : control-unit interface (master side); enables and trap flags are
//              decoded combinationally from state and inputs, INSTRET is registered.
module otter_cu_fsm #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned WAIT_W      = 8
) (
    input  logic            CU_CLK,
    input  logic            CU_RST_N,
    otter_cu_fsm_if.master  bus
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    // Last wait cycle before a timeout; TIMEOUT_CYC >= 1 keeps this non-negative.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_TRAP
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [31:0]       instret_q;
    logic              intr_ok;

    assign intr_ok     = bus.CU_INTR & bus.CU_MIE;
    assign bus.INSTRET = instret_q;

    // State, wait counter and bus-error flag
    always_ff @(posedge CU_CLK or negedge CU_RST_N) begin
        if (!CU_RST_N) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Retired-instruction counter; trap PC loads do not count
    always_ff @(posedge CU_CLK or negedge CU_RST_N) begin
        if (!CU_RST_N) begin
            instret_q <= '0;
        end else if (bus.PC_WRITE && (state_q != ST_TRAP)) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        bus.PC_WRITE  = 1'b0;
        bus.PC_RST    = 1'b0;
        bus.MEM_RDEN1 = 1'b0;
        bus.MEM_RDEN2 = 1'b0;
        bus.MEM_WE2   = 1'b0;
        bus.REG_WRITE = 1'b0;
        bus.CSR_WE    = 1'b0;
        bus.INT_TAKEN = 1'b0;
        bus.BUS_ERR   = 1'b0;

        case (state_q)
            ST_INIT: begin
                bus.PC_RST = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_FETCH: begin
                bus.MEM_RDEN1 = 1'b1;
                if (bus.CU_MEM_RDY) begin
                    state_d = ST_EXEC;
                end else if (cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_TRAP;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end
            ST_EXEC: begin
                if (bus.CU_OPCODE == OP_LOAD) begin
                    bus.MEM_RDEN2 = 1'b1;
                    state_d       = ST_WB;
                end else begin
                    bus.PC_WRITE = 1'b1;
                    case (bus.CU_OPCODE)
                        OP_STORE:  bus.MEM_WE2 = 1'b1;
                        OP_BRANCH: ;
                        OP_SYSTEM: begin
                            if (bus.CU_FUNCT3 == F3_CSRRW) begin
                                bus.CSR_WE    = 1'b1;
                                bus.REG_WRITE = 1'b1;
                            end
                        end
                        default:   bus.REG_WRITE = 1'b1;
                    endcase
                    state_d = intr_ok ? ST_TRAP : ST_FETCH;
                end
            end
            ST_WB: begin
                if (bus.CU_MEM_RDY) begin
                    bus.REG_WRITE = 1'b1;
                    bus.PC_WRITE  = 1'b1;
                    state_d       = intr_ok ? ST_TRAP : ST_FETCH;
                end else if (cnt_q == WAIT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_TRAP;
                end else begin
                    cnt_d = cnt_q + WAIT_W'(1);
                end
            end
            ST_TRAP: begin
                bus.INT_TAKEN = 1'b1;
                bus.PC_WRITE  = 1'b1;
                bus.CSR_WE    = 1'b1;
                bus.BUS_ERR   = err_q;
                err_d         = 1'b0;
                state_d       = ST_FETCH;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Wait counter restarts on every state change
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed testbench for otter_cu_fsm (TIMEOUT_CYC=4).
module tb_otter_cu_fsm;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic CU_CLK;
    logic CU_RST_N;
    int   n_tests;
    int   n_fail;
    int   pcw_cnt;

    otter_cu_fsm_if bus ();

    otter_cu_fsm #(.TIMEOUT_CYC(4), .WAIT_W(8)) dut (
        .CU_CLK   (CU_CLK),
        .CU_RST_N (CU_RST_N),
        .bus      (bus)
    );

    initial CU_CLK = 1'b0;
    always #5 CU_CLK = ~CU_CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; leave time 1 unit past the rising edge
    task automatic step();
        @(posedge CU_CLK);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        CU_RST_N       = 1'b1;
        bus.CU_OPCODE  = OP_R;
        bus.CU_FUNCT3  = 3'b000;
        bus.CU_MEM_RDY = 1'b0;
        bus.CU_INTR    = 1'b0;
        bus.CU_MIE     = 1'b0;
        #2 CU_RST_N = 1'b0;
        #1;
        check("rst_pc_rst",   32'(bus.PC_RST), 32'd1);
        check("rst_pc_write", 32'(bus.PC_WRITE), 32'd0);
        check("rst_rden1",    32'(bus.MEM_RDEN1), 32'd0);
        check("rst_instret",  bus.INSTRET, 32'd0);
        step();
        step();
        CU_RST_N = 1'b0;

        // 1. Release reset: one PC_RST cycle then FETCH
        CU_RST_N = 1'b1;
        #1;
        check("init_pc_rst", 32'(bus.PC_RST), 32'd1);
        step();
        check("fetch_pc_rst", 32'(bus.PC_RST), 32'd0);
        check("fetch_rden1",  32'(bus.MEM_RDEN1), 32'd1);
        check("fetch_instret", bus.INSTRET, 32'd0);

        // 2. Ten R-type instructions
        bus.CU_MEM_RDY = 1'b1;
        bus.CU_OPCODE  = OP_R;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("r_fetch_rden1", 32'(bus.MEM_RDEN1), 32'd1);
            check("r_fetch_pcw",   32'(bus.PC_WRITE), 32'd0);
            step();
            check("r_exec_regw", 32'(bus.REG_WRITE), 32'd1);
            check("r_exec_pcw",  32'(bus.PC_WRITE), 32'd1);
            step();
        end
        check("r_instret10", bus.INSTRET, 32'd10);

        // 3. Load with three stall cycles in WB
        pcw_cnt = 0;
        bus.CU_OPCODE = OP_LOAD;
        #1;
        pcw_cnt += int'(bus.PC_WRITE);
        step();
        bus.CU_MEM_RDY = 1'b0;
        #1;
        check("ld_exec_rden2", 32'(bus.MEM_RDEN2), 32'd1);
        check("ld_exec_pcw",   32'(bus.PC_WRITE), 32'd0);
        pcw_cnt += int'(bus.PC_WRITE);
        step();
        for (int i = 0; i < 3; i++) begin
            check("ld_wait_pcw",  32'(bus.PC_WRITE), 32'd0);
            check("ld_wait_regw", 32'(bus.REG_WRITE), 32'd0);
            pcw_cnt += int'(bus.PC_WRITE);
            step();
        end
        bus.CU_MEM_RDY = 1'b1;
        #1;
        check("ld_rdy_pcw",  32'(bus.PC_WRITE), 32'd1);
        check("ld_rdy_regw", 32'(bus.REG_WRITE), 32'd1);
        pcw_cnt += int'(bus.PC_WRITE);
        step();
        check("ld_back_fetch", 32'(bus.MEM_RDEN1), 32'd1);
        check("ld_pcw_once",   32'(pcw_cnt), 32'd1);
        check("ld_instret",    bus.INSTRET, 32'd11);

        // 4. Store with interrupt pending and enabled -> TRAP
        bus.CU_OPCODE = OP_STORE;
        step();
        bus.CU_INTR = 1'b1;
        bus.CU_MIE  = 1'b1;
        #1;
        check("st_exec_we2",  32'(bus.MEM_WE2), 32'd1);
        check("st_exec_pcw",  32'(bus.PC_WRITE), 32'd1);
        check("st_exec_regw", 32'(bus.REG_WRITE), 32'd0);
        step();
        bus.CU_INTR = 1'b0;
        #1;
        check("trap_taken",  32'(bus.INT_TAKEN), 32'd1);
        check("trap_buserr", 32'(bus.BUS_ERR), 32'd0);
        check("trap_csrwe",  32'(bus.CSR_WE), 32'd1);
        check("trap_pcw",    32'(bus.PC_WRITE), 32'd1);
        step();
        check("trap_exit_fetch", 32'(bus.MEM_RDEN1), 32'd1);
        check("trap_instret",    bus.INSTRET, 32'd12);

        // Store with interrupt but MIE=0 -> no trap
        step();
        bus.CU_INTR = 1'b1;
        bus.CU_MIE  = 1'b0;
        #1;
        check("st2_exec_we2", 32'(bus.MEM_WE2), 32'd1);
        step();
        check("st2_no_trap", 32'(bus.INT_TAKEN), 32'd0);
        check("st2_fetch",   32'(bus.MEM_RDEN1), 32'd1);
        check("st2_instret", bus.INSTRET, 32'd13);
        bus.CU_INTR = 1'b0;

        // csrrw and branch decode
        bus.CU_OPCODE = OP_SYSTEM;
        bus.CU_FUNCT3 = 3'b001;
        step();
        check("csrrw_csrwe", 32'(bus.CSR_WE), 32'd1);
        check("csrrw_regw",  32'(bus.REG_WRITE), 32'd1);
        step();
        bus.CU_OPCODE = OP_BRANCH;
        bus.CU_FUNCT3 = 3'b000;
        step();
        check("br_regw", 32'(bus.REG_WRITE), 32'd0);
        check("br_pcw",  32'(bus.PC_WRITE), 32'd1);
        step();
        bus.CU_OPCODE = OP_SYSTEM;
        step();
        check("sys_csrwe", 32'(bus.CSR_WE), 32'd0);
        check("sys_pcw",   32'(bus.PC_WRITE), 32'd1);
        step();
        check("pre_to_instret", bus.INSTRET, 32'd16);

        // 5. Fetch timeout after 4 wait cycles
        bus.CU_MEM_RDY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("to_wait_rden1", 32'(bus.MEM_RDEN1), 32'd1);
            check("to_wait_taken", 32'(bus.INT_TAKEN), 32'd0);
            step();
        end
        check("to_trap_taken",  32'(bus.INT_TAKEN), 32'd1);
        check("to_trap_buserr", 32'(bus.BUS_ERR), 32'd1);
        check("to_instret",     bus.INSTRET, 32'd16);
        step();
        check("to_exit_buserr", 32'(bus.BUS_ERR), 32'd0);
        check("to_exit_fetch",  32'(bus.MEM_RDEN1), 32'd1);

        // 6. Reset asserted mid-WB
        bus.CU_MEM_RDY = 1'b1;
        bus.CU_OPCODE  = OP_LOAD;
        step();
        bus.CU_MEM_RDY = 1'b0;
        step();
        #2 CU_RST_N = 1'b0;
        #1;
        check("wbrst_pc_rst",  32'(bus.PC_RST), 32'd1);
        check("wbrst_pcw",     32'(bus.PC_WRITE), 32'd0);
        check("wbrst_regw",    32'(bus.REG_WRITE), 32'd0);
        check("wbrst_instret", bus.INSTRET, 32'd0);
        step();
        CU_RST_N = 1'b1;

        // Reset during store EXEC drops MEM_WE2 immediately
        bus.CU_MEM_RDY = 1'b1;
        bus.CU_OPCODE  = OP_STORE;
        step();
        step();
        check("strst_we2_pre", 32'(bus.MEM_WE2), 32'd1);
        CU_RST_N = 1'b0;
        #1;
        check("strst_we2", 32'(bus.MEM_WE2), 32'd0);
        check("strst_pc_rst", 32'(bus.PC_RST), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
